// File: rtl/stream_mux_n.sv
// N-input streaming multiplexer with valid/ready on every port and one registered
// output stage; channel chosen by external sel (MODE=0) or round-robin (MODE=1).

module stream_mux_lane #(
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic            gnt_vld,
  input  logic [SELW-1:0] gnt_idx,
  input  logic            load,
  output logic            ready
);
  // Ready depends only on the grant, never on a losing channel's valid.
  assign ready = gnt_vld && load && (gnt_idx == SELW'(IDX));
endmodule

module stream_mux_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  typedef struct packed {
    logic            vld;
    logic [SELW-1:0] idx;
  } grant_t;

  localparam logic [SELW:0] N_W = (SELW+1)'(N);

  logic [N-1:0][WIDTH-1:0] ch_data;
  assign ch_data = in_data;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load;
  logic             xfer;
  grant_t           gnt;
  logic [SELW:0]    rr_idx;
  logic [SELW:0]    ptr_inc;

  assign load = !out_valid_q || out_ready;

  always_comb begin
    gnt    = '0;
    rr_idx = '0;
    if (MODE == 0) begin
      // Out-of-range select (possible when N is not a power of two) never grants.
      if ({1'b0, sel} < N_W) begin
        if (in_valid[sel]) begin
          gnt.vld = 1'b1;
          gnt.idx = sel;
        end
      end
    end else begin
      // Search starts at ptr and wraps; the first valid channel wins.
      for (int i = 0; i < N; i++) begin
        rr_idx = {1'b0, ptr_q} + (SELW+1)'(i);
        if (rr_idx >= N_W) rr_idx = rr_idx - N_W;
        if (!gnt.vld && in_valid[rr_idx[SELW-1:0]]) begin
          gnt.vld = 1'b1;
          gnt.idx = rr_idx[SELW-1:0];
        end
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    stream_mux_lane #(.SELW(SELW), .IDX(k)) u_lane (
      .gnt_vld (gnt.vld),
      .gnt_idx (gnt.idx),
      .load    (load),
      .ready   (in_ready[k])
    );
  end

  assign xfer    = gnt.vld && load;
  assign ptr_inc = {1'b0, gnt.idx} + (SELW+1)'(1);

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      // Reload on the same edge a held word is consumed: no bubble.
      out_data_d  = ch_data[gnt.idx];
      out_chan_d  = gnt.idx;
      out_valid_d = 1'b1;
      if (MODE != 0) ptr_d = (ptr_inc >= N_W) ? '0 : ptr_inc[SELW-1:0];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: directed scenarios plus randomized traffic on a
// select-mode and a round-robin instance, checked against a transaction-level model.

module tb_stream_mux_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u0: MODE=0 N=4, u1: MODE=1 N=4, u2: MODE=0 N=3
  logic [31:0] d0_in_data, d1_in_data;
  logic [23:0] d2_in_data;
  logic [3:0]  d0_in_valid, d1_in_valid, d0_in_ready, d1_in_ready;
  logic [2:0]  d2_in_valid, d2_in_ready;
  logic [1:0]  d0_sel, d1_sel, d2_sel;
  logic [7:0]  d0_out_data, d1_out_data, d2_out_data;
  logic        d0_out_valid, d1_out_valid, d2_out_valid;
  logic        d0_out_ready, d1_out_ready, d2_out_ready;
  logic [1:0]  d0_out_chan, d1_out_chan, d2_out_chan;

  stream_mux_n #(.WIDTH(8), .N(4), .MODE(0), .SELW(2)) u0 (
    .clk(clk), .rst(rst), .in_data(d0_in_data), .in_valid(d0_in_valid),
    .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_chan(d0_out_chan));

  stream_mux_n #(.WIDTH(8), .N(4), .MODE(1), .SELW(2)) u1 (
    .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_chan(d1_out_chan));

  stream_mux_n #(.WIDTH(8), .N(3), .MODE(0), .SELW(2)) u2 (
    .clk(clk), .rst(rst), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .sel(d2_sel), .out_data(d2_out_data),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_chan(d2_out_chan));

  // Reference grant: which channel would be taken this cycle, -1 if none.
  function automatic int ref_grant(int mode, int n, logic [3:0] v, int s, int p);
    if (mode == 0) return (s < n && v[s]) ? s : -1;
    for (int i = 0; i < n; i++)
      if (v[(p + i) % n]) return (p + i) % n;
    return -1;
  endfunction

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    d0_in_valid = 4'b1111; d1_in_valid = 4'b1111; d2_in_valid = 3'b111;
    d0_out_ready = 1'b0; d1_out_ready = 1'b0; d2_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({d0_out_valid, d1_out_valid, d2_out_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_valid got %b want 000", {d0_out_valid, d1_out_valid, d2_out_valid});
    end
    checks++;
    if ({d0_out_data, d1_out_data, d2_out_data} !== 24'h0) begin
      errors++; $display("FAIL reset_data got %h want 000000", {d0_out_data, d1_out_data, d2_out_data});
    end
    checks++;
    if ({d0_out_chan, d1_out_chan, d2_out_chan} !== 6'h0) begin
      errors++; $display("FAIL reset_chan got %b want 000000", {d0_out_chan, d1_out_chan, d2_out_chan});
    end
    @(negedge clk); rst = 1'b0;
    d0_in_valid = '0; d1_in_valid = '0; d2_in_valid = '0;
  endtask

  task automatic test_sel_switch();
    int sels [3] = '{2, 0, 3};
    logic [7:0] exp_d;
    @(negedge clk);
    d0_in_data = 32'h44332211; d0_in_valid = 4'b1111; d0_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d0_sel = 2'(sels[i]);
      @(posedge clk); #1;
      exp_d = 8'(8'h11 * (sels[i] + 1));
      checks++;
      if (d0_out_valid !== 1'b1 || d0_out_data !== exp_d || d0_out_chan !== 2'(sels[i])) begin
        errors++; $display("FAIL sel_switch[%0d] got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                           i, d0_out_valid, d0_out_data, d0_out_chan, exp_d, sels[i]);
      end
      @(negedge clk);
    end
    d0_in_valid = '0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_rr_fairness();
    int exp_c [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
    pulse_reset();
    d1_in_data = 32'hD4C3B2A1; d1_in_valid = 4'b1111; d1_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) d1_in_valid = 4'b1101;
      @(posedge clk); #1;
      checks++;
      if (d1_out_valid !== 1'b1 || d1_out_chan !== 2'(exp_c[i]) ||
          d1_out_data !== d1_in_data[exp_c[i]*8 +: 8]) begin
        errors++; $display("FAIL rr_fair[%0d] got v=%b c=%0d d=%h want v=1 c=%0d d=%h",
                           i, d1_out_valid, d1_out_chan, d1_out_data, exp_c[i], d1_in_data[exp_c[i]*8 +: 8]);
      end
      @(negedge clk);
    end
    d1_in_valid = '0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    d0_in_data = 32'h44332211; d0_in_valid = 4'b1111; d0_sel = 2'd1; d0_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d0_out_ready = 1'b0; d0_sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (d0_in_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_ready[%0d] got %b want 0000", i, d0_in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (d0_out_valid !== 1'b1 || d0_out_data !== 8'h22 || d0_out_chan !== 2'd1) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h c=%0d want v=1 d=22 c=1",
                           i, d0_out_valid, d0_out_data, d0_out_chan);
      end
      @(negedge clk);
    end
    d0_out_ready = 1'b1;
    #1;
    checks++;
    if (d0_in_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_release_ready got %b want 0100", d0_in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (d0_out_valid !== 1'b1 || d0_out_data !== 8'h33 || d0_out_chan !== 2'd2) begin
      errors++; $display("FAIL bp_release got v=%b d=%h c=%0d want v=1 d=33 c=2",
                         d0_out_valid, d0_out_data, d0_out_chan);
    end
    @(negedge clk);
    d0_in_valid = '0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_boundary();
    pulse_reset();
    d2_in_data = 24'h332211; d2_in_valid = 3'b111; d2_sel = 2'd3; d2_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (d2_in_ready !== 3'b000) begin
        errors++; $display("FAIL oob_ready[%0d] got %b want 000", i, d2_in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (d2_out_valid !== 1'b0) begin
        errors++; $display("FAIL oob_valid[%0d] got %b want 0", i, d2_out_valid);
      end
      @(negedge clk);
    end
    d2_sel = 2'd2;
    @(posedge clk); #1;
    checks++;
    if (d2_out_valid !== 1'b1 || d2_out_data !== 8'h33 || d2_out_chan !== 2'd2) begin
      errors++; $display("FAIL n3_top got v=%b d=%h c=%0d want v=1 d=33 c=2", d2_out_valid, d2_out_data, d2_out_chan);
    end
    @(negedge clk);
    d2_in_valid = '0;
    // Round-robin wrap from the last channel back to 0
    d1_in_data = 32'hD4C3B2A1; d1_in_valid = 4'b1000; d1_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (d1_out_valid !== 1'b1 || d1_out_chan !== 2'd3 || d1_out_data !== 8'hD4) begin
      errors++; $display("FAIL rr_only3 got v=%b c=%0d d=%h want v=1 c=3 d=d4", d1_out_valid, d1_out_chan, d1_out_data);
    end
    @(negedge clk);
    d1_in_valid = 4'b1111;
    @(posedge clk); #1;
    checks++;
    if (d1_out_chan !== 2'd0 || d1_out_data !== 8'hA1) begin
      errors++; $display("FAIL rr_wrap got c=%0d d=%h want c=0 d=a1", d1_out_chan, d1_out_data);
    end
    @(negedge clk);
    d1_in_valid = '0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    pulse_reset();
    d1_in_data = 32'hD4C3B2A1; d1_in_valid = 4'b1111; d1_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    d1_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (d1_out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid got %b want 0", d1_out_valid);
    end
    @(negedge clk);
    rst = 1'b0; d1_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (d1_out_valid !== 1'b1 || d1_out_chan !== 2'd0 || d1_out_data !== 8'hA1) begin
      errors++; $display("FAIL midrst_restart got v=%b c=%0d d=%h want v=1 c=0 d=a1", d1_out_valid, d1_out_chan, d1_out_data);
    end
    @(negedge clk);
    d1_in_valid = '0;
    @(posedge clk); @(negedge clk);
  endtask

  // Randomized traffic on u0 and u1 together; index 0 = u0 (select), 1 = u1 (round-robin).
  task automatic test_random();
    logic       mv [2];
    logic [7:0] md [2];
    int         mc [2];
    int         mp [2];
    int         g  [2];
    logic       ld [2];
    logic [3:0] exp_rdy;
    pulse_reset();
    for (int m = 0; m < 2; m++) begin mv[m] = 0; md[m] = 0; mc[m] = 0; mp[m] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      d0_in_data = $urandom; d0_in_valid = 4'($urandom); d0_sel = 2'($urandom);
      d0_out_ready = ($urandom_range(0, 3) != 0);
      d1_in_data = $urandom; d1_in_valid = 4'($urandom);
      d1_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g[0]  = ref_grant(0, 4, d0_in_valid, int'(d0_sel), 0);
      g[1]  = ref_grant(1, 4, d1_in_valid, 0, mp[1]);
      ld[0] = !mv[0] || d0_out_ready;
      ld[1] = !mv[1] || d1_out_ready;
      exp_rdy = (g[0] >= 0 && ld[0]) ? 4'(1 << g[0]) : 4'b0;
      checks++;
      if (d0_in_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_sel_ready[%0d] got %b want %b", cyc, d0_in_ready, exp_rdy);
      end
      exp_rdy = (g[1] >= 0 && ld[1]) ? 4'(1 << g[1]) : 4'b0;
      checks++;
      if (d1_in_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_rr_ready[%0d] got %b want %b", cyc, d1_in_ready, exp_rdy);
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
        if (g[m] >= 0 && ld[m]) begin
          md[m] = (m == 0) ? d0_in_data[g[m]*8 +: 8] : d1_in_data[g[m]*8 +: 8];
          mc[m] = g[m]; mv[m] = 1'b1;
          if (m == 1) mp[m] = (g[m] + 1) % 4;
        end else if (mv[m] && ((m == 0) ? d0_out_ready : d1_out_ready)) begin
          mv[m] = 1'b0;
        end
      end
      #1;
      checks++;
      if (d0_out_valid !== mv[0] || d0_out_data !== md[0] || d0_out_chan !== 2'(mc[0])) begin
        errors++; $display("FAIL rnd_sel_out[%0d] got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                           cyc, d0_out_valid, d0_out_data, d0_out_chan, mv[0], md[0], mc[0]);
      end
      checks++;
      if (d1_out_valid !== mv[1] || d1_out_data !== md[1] || d1_out_chan !== 2'(mc[1])) begin
        errors++; $display("FAIL rnd_rr_out[%0d] got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                           cyc, d1_out_valid, d1_out_data, d1_out_chan, mv[1], md[1], mc[1]);
      end
      @(negedge clk);
    end
    d0_in_valid = '0; d1_in_valid = '0;
  endtask

  initial begin
    d0_in_data = '0; d1_in_data = '0; d2_in_data = '0;
    d0_in_valid = '0; d1_in_valid = '0; d2_in_valid = '0;
    d0_sel = '0; d1_sel = '0; d2_sel = '0;
    d0_out_ready = 1'b0; d1_out_ready = 1'b0; d2_out_ready = 1'b0;
    test_reset();
    test_sel_switch();
    test_rr_fairness();
    test_backpressure();
    test_boundary();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
